// File: rtl/mem_responder_if.sv
// Request/acknowledge bus between the CPU (master) and the on-chip memory
// responder (slave): an instruction-fetch port and a data load/store port.
interface mem_responder_if #(
  parameter int XLEN = 32
);
  logic            i_inst_req;
  logic [XLEN-1:0] i_inst_addr;
  logic            o_inst_ack;
  logic [XLEN-1:0] o_inst_data;

  logic            i_data_req;
  logic [XLEN-1:0] i_data_addr;
  logic [XLEN-1:0] i_data;
  logic [2:0]      i_funct3;
  logic            i_readwrite_signal;
  logic            o_data_ack;
  logic [XLEN-1:0] o_data_received;
  logic            o_misaligned;

  modport master (
    output i_inst_req, i_inst_addr,
    input  o_inst_ack, o_inst_data,
    output i_data_req, i_data_addr, i_data, i_funct3, i_readwrite_signal,
    input  o_data_ack, o_data_received, o_misaligned
  );

  modport slave (
    input  i_inst_req, i_inst_addr,
    output o_inst_ack, o_inst_data,
    input  i_data_req, i_data_addr, i_data, i_funct3, i_readwrite_signal,
    output o_data_ack, o_data_received, o_misaligned
  );
endinterface

// File: rtl/mem_responder.sv
// Single-ported on-chip memory responder for the instruction-fetch and data
// ports. One request at a time, data port has priority, fixed latency, RV32I
// byte/half/word sizing with sign extension and misalignment detection.
module mem_responder #(
  parameter int    XLEN        = 32,
  parameter int    DEPTH_WORDS = 4096,
  parameter int    LATENCY     = 2,
  parameter string INIT_FILE   = ""
) (
  input logic           i_clk,
  input logic           i_rst_n,
  mem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic            cap_inst;
  logic            cap_rw;
  logic [AW+1:0]   cap_addr;
  logic [31:0]     cap_data;
  logic [2:0]      cap_f3;

  logic [31:0]     mem [DEPTH_WORDS];

  logic [AW-1:0]   idx;
  logic [1:0]      lane;
  logic [31:0]     word;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [XLEN-1:0] ld_data;
  logic            mis;
  logic [3:0]      be;
  logic [31:0]     wdata;
  logic            access;
  logic            wr_en;
  logic            unused_addr_hi;

  // Only addr[AW+1:0] selects a location; higher bits wrap.
  assign unused_addr_hi = ^{bus.i_inst_addr[XLEN-1:AW+2], bus.i_data_addr[XLEN-1:AW+2]};

  assign idx  = cap_addr[AW+1:2];
  assign lane = cap_addr[1:0];

  // Fetch the addressed word and pick out the byte/halfword lanes.
  always_comb begin
    word     = mem[idx];
    byte_sel = word[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? word[31:16] : word[15:0];
  end

  // Decode funct3 into load result, store byte enables and misalignment.
  always_comb begin
    ld_data = '0;
    mis     = 1'b0;
    be      = '0;
    wdata   = '0;
    case (cap_f3)
      3'b000: begin
        ld_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
        be      = 4'b0001 << lane;
        wdata   = {4{cap_data[7:0]}};
      end
      3'b001: begin
        mis = lane[0];
        if (!lane[0]) begin
          ld_data = {{(XLEN-16){half_sel[15]}}, half_sel};
          be      = lane[1] ? 4'b1100 : 4'b0011;
          wdata   = {2{cap_data[15:0]}};
        end
      end
      3'b010: begin
        mis = (lane != 2'b00);
        if (lane == 2'b00) begin
          ld_data = XLEN'(word);
          be      = '1;
          wdata   = cap_data;
        end
      end
      3'b100: ld_data = {{(XLEN-8){1'b0}}, byte_sel};
      3'b101: begin
        // LHU only exists as a load; a store with this funct3 is simply ignored.
        mis = lane[0] & ~cap_rw;
        if (!lane[0]) ld_data = {{(XLEN-16){1'b0}}, half_sel};
      end
      default: ;
    endcase
  end

  // The access happens on the edge that moves BUSY into RESP; RESP is the ack cycle.
  assign access = (state == BUSY) && (cnt == '0);
  assign wr_en  = access && cap_rw && !cap_inst;

  // Byte-enabled store into the array; contents survive reset.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Request FSM: capture in IDLE, count out the latency in BUSY, ack in RESP.
  // LATENCY=1 spends a single cycle in BUSY with count 0 so that the ack still
  // lands exactly LATENCY edges after acceptance.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state               <= IDLE;
      cnt                 <= '0;
      cap_inst            <= 1'b0;
      cap_rw              <= 1'b0;
      cap_addr            <= '0;
      cap_data            <= '0;
      cap_f3              <= '0;
      bus.o_inst_ack      <= 1'b0;
      bus.o_inst_data     <= '0;
      bus.o_data_ack      <= 1'b0;
      bus.o_data_received <= '0;
      bus.o_misaligned    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_data_req) begin
            cap_inst <= 1'b0;
            cap_rw   <= bus.i_readwrite_signal;
            cap_addr <= bus.i_data_addr[AW+1:0];
            cap_data <= bus.i_data[31:0];
            cap_f3   <= bus.i_funct3;
            cnt      <= 4'(LATENCY - 1);
            state    <= BUSY;
          end else if (bus.i_inst_req) begin
            cap_inst <= 1'b1;
            cap_rw   <= 1'b0;
            cap_addr <= bus.i_inst_addr[AW+1:0];
            cap_data <= '0;
            cap_f3   <= 3'b010;
            cnt      <= 4'(LATENCY - 1);
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state <= RESP;
            if (cap_inst) begin
              bus.o_inst_ack  <= 1'b1;
              bus.o_inst_data <= XLEN'(word);
            end else begin
              bus.o_data_ack      <= 1'b1;
              bus.o_misaligned    <= mis;
              bus.o_data_received <= (cap_rw || mis) ? '0 : ld_data;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          bus.o_inst_ack      <= 1'b0;
          bus.o_inst_data     <= '0;
          bus.o_data_ack      <= 1'b0;
          bus.o_data_received <= '0;
          bus.o_misaligned    <= 1'b0;
          state               <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
